// File: rtl/slot_reel_controller.sv
// Three-reel slot machine sequencer: spins BCD reels at a divided clock rate,
// freezes each reel on its stop button and scores the final combination.
module slot_reel_controller #(
  parameter int TICK_DIV = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] stop_btn,
  output logic [3:0] reel0_bcd,
  output logic [3:0] reel1_bcd,
  output logic [3:0] reel2_bcd,
  output logic [2:0] spinning,
  output logic       result_valid,
  output logic       win,
  output logic       pair
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    RESULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             start_p1;
  logic [2:0]       stop_p1;

  logic             start_edge;
  logic [2:0]       stop_edge;
  logic             tick;
  logic [2:0]       advance;

  // Reel step functions keep every digit inside 0-9 even from an illegal value.
  function automatic logic [3:0] step_up1(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] step_down1(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  function automatic logic [3:0] step_up3(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : (d >= 4'd7) ? d - 4'd7 : d + 4'd3;
  endfunction

  function automatic logic score_win(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c);
    return (a == b) && (b == c);
  endfunction

  function automatic logic score_pair(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c);
    return !score_win(a, b, c) && ((a == b) || (b == c) || (a == c));
  endfunction

  assign start_edge = start & ~start_p1;
  assign stop_edge  = stop_btn & ~stop_p1;
  assign tick       = (tick_cnt == CNT_LAST);
  // A stop edge landing on a tick freezes the reel at its pre-tick value.
  assign advance    = spinning & ~stop_edge & {3{tick}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      start_p1     <= 1'b0;
      stop_p1      <= 3'b000;
      reel0_bcd    <= 4'd0;
      reel1_bcd    <= 4'd0;
      reel2_bcd    <= 4'd0;
      spinning     <= 3'b000;
      result_valid <= 1'b0;
      win          <= 1'b0;
      pair         <= 1'b0;
    end else begin
      start_p1 <= start;
      stop_p1  <= stop_btn;
      case (state)
        SPIN: begin
          if (spinning == 3'b000) begin
            state        <= RESULT;
            tick_cnt     <= '0;
            result_valid <= 1'b1;
            win          <= score_win(reel0_bcd, reel1_bcd, reel2_bcd);
            pair         <= score_pair(reel0_bcd, reel1_bcd, reel2_bcd);
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            spinning <= spinning & ~stop_edge;
            if (advance[0]) reel0_bcd <= step_up1(reel0_bcd);
            if (advance[1]) reel1_bcd <= step_down1(reel1_bcd);
            if (advance[2]) reel2_bcd <= step_up3(reel2_bcd);
          end
        end
        IDLE, RESULT: begin
          tick_cnt <= '0;
          if (start_edge) begin
            state        <= SPIN;
            spinning     <= 3'b111;
            result_valid <= 1'b0;
            win          <= 1'b0;
            pair         <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          spinning <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_reel_controller.sv
// Bench for slot_reel_controller: directed game scenarios plus random button
// activity, all compared every cycle against a behavioural game model.
module tb_slot_reel_controller;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] stop_btn = 3'b000;
  logic [3:0] reel0_bcd, reel1_bcd, reel2_bcd;
  logic [2:0] spinning;
  logic       result_valid, win, pair;

  slot_reel_controller #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_btn(stop_btn),
    .reel0_bcd(reel0_bcd), .reel1_bcd(reel1_bcd), .reel2_bcd(reel2_bcd),
    .spinning(spinning), .result_valid(result_valid), .win(win), .pair(pair)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Behavioural model: game phase, cycles spent spinning, reel digits as ints.
  int       m_phase = 0;  // 0 idle, 1 spinning, 2 showing result
  int       m_since = 0;
  int       m_reel[3] = '{0, 0, 0};
  bit [2:0] m_spin = 3'b000;
  bit       m_rv = 1'b0, m_win = 1'b0, m_pair = 1'b0;
  bit       m_prev_start = 1'b0;
  bit [2:0] m_prev_stop = 3'b000;

  always @(posedge clk) begin
    bit se;
    bit [2:0] sp;
    bit tk;
    int distinct;
    if (rst) begin
      m_phase = 0; m_since = 0; m_reel = '{0, 0, 0}; m_spin = 3'b000;
      m_rv = 0; m_win = 0; m_pair = 0; m_prev_start = 0; m_prev_stop = 3'b000;
    end else begin
      se = start && !m_prev_start;
      sp = stop_btn & ~m_prev_stop;
      if (m_phase == 1) begin
        if (m_spin == 3'b000) begin
          distinct = 1 + int'(m_reel[1] != m_reel[0])
                       + int'(m_reel[2] != m_reel[0] && m_reel[2] != m_reel[1]);
          m_phase = 2; m_rv = 1;
          m_win = (distinct == 1);
          m_pair = (distinct == 2);
        end else begin
          tk = (m_since % TICK_DIV) == TICK_DIV - 1;
          m_since++;
          for (int i = 0; i < 3; i++) begin
            if (m_spin[i]) begin
              if (sp[i]) m_spin[i] = 1'b0;
              else if (tk) m_reel[i] = (m_reel[i] + ((i == 0) ? 1 : (i == 1) ? 9 : 3)) % 10;
            end
          end
        end
      end else if (se) begin
        m_phase = 1; m_since = 0; m_spin = 3'b111; m_rv = 0; m_win = 0; m_pair = 0;
      end
      m_prev_start = start;
      m_prev_stop = stop_btn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model reel0", reel0_bcd, m_reel[0]);
      check("model reel1", reel1_bcd, m_reel[1]);
      check("model reel2", reel2_bcd, m_reel[2]);
      check("model spinning", spinning, m_spin);
      check("model result_valid", result_valid, m_rv);
      check("model win", win, m_win);
      check("model pair", pair, m_pair);
      check("reels in range", (reel0_bcd <= 9) && (reel1_bcd <= 9) && (reel2_bcd <= 9), 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop_btn = 3'b000;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic reels_are(input string name, input int a, input int b, input int c);
    check({name, " r0"}, reel0_bcd, a);
    check({name, " r1"}, reel1_bcd, b);
    check({name, " r2"}, reel2_bcd, c);
  endtask

  task automatic begin_game();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    cyc(1);
    do_reset();
    chk_en = 1'b1;

    // Reset state, then a stop edge in IDLE.
    reels_are("reset", 0, 0, 0);
    check("reset spinning", spinning, 0);
    check("reset result_valid", result_valid, 0);
    check("reset win", win, 0);
    check("reset pair", pair, 0);
    stop_btn = 3'b111;
    cyc(1);
    stop_btn = 3'b000;
    check("idle stop spinning", spinning, 0);
    reels_are("idle stop", 0, 0, 0);

    // Free spin: step spacing, 3 ticks, mid-spin start, 10 ticks.
    do_reset();
    begin_game();
    check("spin entry", spinning, 3'b111);
    reels_are("spin entry", 0, 0, 0);
    cyc(3);
    reels_are("before tick1", 0, 0, 0);
    cyc(1);
    reels_are("tick1", 1, 9, 3);
    cyc(7);
    reels_are("before tick3", 2, 8, 6);
    cyc(1);
    reels_are("tick3", 3, 7, 9);
    begin_game();
    cyc(27);
    reels_are("tick10", 0, 0, 0);
    check("tick10 spinning", spinning, 3'b111);

    // Win after tick 5.
    do_reset();
    begin_game();
    cyc(20);
    reels_are("tick5", 5, 5, 5);
    stop_btn = 3'b111;
    cyc(1);
    stop_btn = 3'b000;
    check("win stop spinning", spinning, 0);
    check("win rv early", result_valid, 0);
    cyc(1);
    reels_are("win", 5, 5, 5);
    check("win rv", result_valid, 1);
    check("win win", win, 1);
    check("win pair", pair, 0);

    // Pair 1,1,2, then restart from held reels.
    do_reset();
    begin_game();
    cyc(4);
    stop_btn = 3'b001; cyc(1); stop_btn = 3'b000;
    check("pair stop0 spinning", spinning, 3'b110);
    cyc(11);
    stop_btn = 3'b100; cyc(1); stop_btn = 3'b000;
    check("pair stop2 spinning", spinning, 3'b010);
    cyc(19);
    stop_btn = 3'b010; cyc(1); stop_btn = 3'b000;
    cyc(1);
    reels_are("pair", 1, 1, 2);
    check("pair rv", result_valid, 1);
    check("pair win", win, 0);
    check("pair pair", pair, 1);
    begin_game();
    check("restart rv", result_valid, 0);
    check("restart pair", pair, 0);
    check("restart spinning", spinning, 3'b111);
    reels_are("restart", 1, 1, 2);

    // Stop edge coinciding with the tick that would move reel2 6 -> 9.
    do_reset();
    begin_game();
    cyc(11);
    stop_btn = 3'b100; cyc(1); stop_btn = 3'b000;
    reels_are("stop on tick", 3, 7, 6);
    check("stop on tick spinning", spinning, 3'b011);

    // Reset mid-spin with start held through release.
    do_reset();
    begin_game();
    cyc(8);
    stop_btn = 3'b010; cyc(1); stop_btn = 3'b000;
    check("mid spin spinning", spinning, 3'b101);
    reels_are("mid spin", 2, 8, 6);
    rst = 1'b1; start = 1'b1;
    cyc(1);
    rst = 1'b0;
    reels_are("abort", 0, 0, 0);
    check("abort spinning", spinning, 0);
    check("abort rv", result_valid, 0);
    cyc(1);
    check("held start restart", spinning, 3'b111);
    start = 1'b0;

    // Random button activity with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) start = ~start;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) stop_btn[b] = ~stop_btn[b];
      cyc(1);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/slot_reel_controller.md
Name: slot_reel_controller

Overview:
Game sequencer for the three-reel 7-segment slot machine. It spins three BCD reel counters at a divided clock rate and freezes each reel on its stop button. When all reels are stopped it scores the result. The reel0/1/2_bcd outputs drive the per-digit BCD-to-7-segment decoders directly; outputs are always in the range 0-9.

Parameters:
TICK_DIV, 2500000, clk cycles per reel step (20 Hz at 50 MHz); legal range >= 2; the bench uses 4.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  start button; pre-debounced, synchronous level; rising edge used
stop_btn  input  3  per-reel stop buttons; pre-debounced, synchronous level; rising edge used; bit i = reel i
reel0_bcd  output  4  reel 0 digit, 0-9
reel1_bcd  output  4  reel 1 digit, 0-9
reel2_bcd  output  4  reel 2 digit, 0-9
spinning  output  3  bit i high while reel i is spinning
result_valid  output  1  high while in RESULT
win  output  1  all three reels equal; qualified by result_valid
pair  output  1  exactly two reels equal; qualified by result_valid

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE; reels = 0; spinning = 000; result_valid, win, pair = 0.
  - Tick counter = 0; edge-detect history registers = 0.
  - A button held high through reset release therefore produces one edge.
  - Reset mid-spin or mid-result aborts the game immediately, with the same values.
- Edge detection: an edge in cycle N means the input is high in cycle N and was low in cycle N-1. All state changes it causes are visible at N+1.
- States: IDLE, SPIN, RESULT.
- IDLE:
  - A start edge moves to SPIN. On that transition: spinning = 111, tick counter = 0, result_valid/win/pair = 0.
  - Stop edges are ignored.
- SPIN:
  - The tick counter counts 0..TICK_DIV-1 and wraps. tick = (counter == TICK_DIV-1).
  - The first step occurs TICK_DIV cycles after SPIN entry.
  - On tick, each reel whose spinning bit is set steps:
    - reel0 = +1 mod 10 (9 -> 0)
    - reel1 = -1 mod 10 (0 -> 9)
    - reel2 = +3 mod 10 (7 -> 0, 8 -> 1, 9 -> 2)
  - Stop edge on bit i with spinning[i] = 1: spinning[i] clears next cycle and reel i freezes.
  - A stop edge coinciding with a tick wins: the reel keeps its pre-tick value.
  - Stop edges on already-stopped reels are ignored. Multiple simultaneous stop edges are all honoured.
  - Start edges are ignored.
  - When spinning is 000 at a clk edge, the state moves to RESULT. win, pair and result_valid are registered at that same edge, so result_valid rises exactly one cycle after the last spinning bit clears.
- Scoring:
  - win = (r0 == r1) and (r1 == r2).
  - pair = not win and ((r0 == r1) or (r1 == r2) or (r0 == r2)).
- RESULT:
  - Reels, win, pair and result_valid are held.
  - Stop edges are ignored.
  - A start edge starts a new game exactly as from IDLE. Reels resume from their held values; they are not zeroed.
- Reel values never leave 0-9.
- The tick counter is idle (held at 0) outside SPIN.

Test Plan:
1. Reset: drive rst 2 cycles with start and stop_btn low. Required: reels = 0, spinning = 000, result_valid/win/pair = 0. A stop edge in IDLE changes nothing.
2. Free spin, TICK_DIV=4: one start edge, then no stops.
   - After 3 ticks: reels = 3, 7, 9.
   - After 10 ticks: reels = 0, 0, 0.
   - Steps are spaced exactly 4 cycles apart; the first step is 4 cycles after SPIN entry.
   - A repeated start edge mid-spin has no effect.
3. Win: stop edges on all three bits together after the 5th tick. Required: reels frozen at 5, 5, 5; spinning 111 -> 000 in one cycle; one cycle later result_valid = 1, win = 1, pair = 0.
4. Pair: stop reel0 after tick 1, reel2 after tick 4, reel1 after tick 9. Required: reels = 1, 1, 2; result_valid = 1, win = 0, pair = 1. A new start edge clears result_valid/win/pair next cycle and resumes from 1, 1, 2.
5. Stop on tick: assert a reel2 stop edge in the tick cycle where reel2 would go 6 -> 9. Required: reel2 holds 6 while the other reels step.
6. Reset mid-spin, with reels nonzero and spinning = 101: assert rst 1 cycle. Required: next cycle IDLE, reels 0, spinning 000. With start held high during and after reset, a new game begins one cycle after rst deasserts.
